psu_sequence_monitor: RTL

- Receive-side checker for the PSU control bus. It samples ctl0/ctl1 and the four read/write strobes produced by the PSU sequencer.
- It decodes each sample back to (phase, step), locks onto the running sequence, and flags any illegal or out-of-order word.
- Sits in the same clock domain as the sequencer, next to the adiabatic supply. Feeds status and error flags to the test/debug logic.

---
 rtl/psu_mon_pkg.sv | 17 +
 rtl/psu_ctl_decode.sv | 49 ++++
 rtl/psu_sequence_monitor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/psu_mon_pkg.sv
// Shared types and constants for the PSU control-bus sequence monitor.
package psu_mon_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_SEQ     = 2'd2;
    localparam logic [1:0] ERR_STRB    = 2'd3;

endpackage

// File: rtl/psu_ctl_decode.sv
// Combinational decoder: maps a (ctl0, ctl1) sample back to (phase, step).
// A word is legal only if it exactly equals one of the 4*steps encodings,
// which implies exactly two bits set across both buses.
module psu_ctl_decode
    import psu_mon_pkg::*;
#(
    parameter int steps = 8
) (
    input  logic [steps:0]           ctl0,
    input  logic [steps:0]           ctl1,
    output logic                     legal,
    output logic [PHASE_W-1:0]       phase,
    output logic [$clog2(steps)-1:0] step
);

    localparam int SW = $clog2(steps);
    localparam logic [steps:0] ONE = {{steps{1'b0}}, 1'b1};
    localparam logic [steps:0] TOP = ONE << steps;

    logic [steps-1:0] w_m0;
    logic [steps-1:0] w_m1;
    logic [steps-1:0] w_m2;
    logic [steps-1:0] w_m3;

    // One exact-match comparator per (phase, step) encoding.
    genvar gi;
    generate
        for (gi = 0; gi < steps; gi++) begin : g_match
            assign w_m0[gi] = (ctl1 == ONE) && (ctl0 == (ONE << (gi + 1)));
            assign w_m1[gi] = (ctl0 == TOP) && (ctl1 == (ONE << (gi + 1)));
            assign w_m2[gi] = (ctl1 == TOP) && (ctl0 == (ONE << (steps - 1 - gi)));
            assign w_m3[gi] = (ctl0 == ONE) && (ctl1 == (ONE << (steps - 1 - gi)));
        end
    endgenerate

    // Encodings are mutually exclusive, so at most one match fires.
    always_comb begin
        legal = 1'b0;
        phase = '0;
        step  = '0;
        for (int j = 0; j < steps; j++) begin
            if (w_m0[j]) begin legal = 1'b1; phase = PHASE_W'(0); step = SW'(j); end
            if (w_m1[j]) begin legal = 1'b1; phase = PHASE_W'(1); step = SW'(j); end
            if (w_m2[j]) begin legal = 1'b1; phase = PHASE_W'(2); step = SW'(j); end
            if (w_m3[j]) begin legal = 1'b1; phase = PHASE_W'(3); step = SW'(j); end
        end
    end

endmodule

// File: rtl/psu_sequence_monitor.sv
// Receive-side sequence checker for the PSU control bus.
// Decodes each sample, locks after lock_cycles in-order words and reports
// illegal words, sequence breaks and strobe mismatches while locked.
// Optional macro PSU_MON_ERR_CAPTURE_EN adds a first-error sample capture.
module psu_sequence_monitor
    import psu_mon_pkg::*;
#(
    parameter int steps       = 8,
    parameter int lock_cycles = 4,
    parameter int cnt_w       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [steps:0]           ctl0,
    input  logic [steps:0]           ctl1,
    input  logic                     r0_w2_en,
    input  logic                     r1_w3_en,
    input  logic                     r2_w0_en,
    input  logic                     r3_w1_en,
    output logic                     locked,
    output logic [PHASE_W-1:0]       phase_o,
    output logic [$clog2(steps)-1:0] step_o,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [cnt_w-1:0]         err_count
`ifdef PSU_MON_ERR_CAPTURE_EN
    ,
    output logic [steps:0]           cap_ctl0,
    output logic [steps:0]           cap_ctl1,
    output logic [3:0]               cap_strb,
    output logic                     cap_valid
`endif
);

    localparam int SW = $clog2(steps);
    localparam logic [SW-1:0] LAST_STEP = SW'(steps - 1);
    localparam logic [7:0]    LOCK_N    = 8'(lock_cycles);

    logic                w_legal;
    logic [PHASE_W-1:0]  w_phase;
    logic [SW-1:0]       w_step;
    logic                w_last;
    logic [3:0]          w_strb;
    logic [3:0]          w_exp_strb;
    logic                w_in_seq;
    logic [1:0]          w_class;
    logic [PHASE_W-1:0]  w_succ_phase;
    logic [SW-1:0]       w_succ_step;

    mon_state_t          r_state;
    mon_state_t          w_state_next;
    logic [7:0]          r_match_cnt;
    logic [7:0]          w_cnt_next;
    logic                w_load_exp;
    logic                w_err_fire;

    logic [PHASE_W-1:0]  r_exp_phase;
    logic [SW-1:0]       r_exp_step;
    logic [PHASE_W-1:0]  r_phase;
    logic [SW-1:0]       r_step;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [cnt_w-1:0]    r_err_count;

    psu_ctl_decode #(.steps(steps)) u_decode (
        .ctl0  (ctl0),
        .ctl1  (ctl1),
        .legal (w_legal),
        .phase (w_phase),
        .step  (w_step)
    );

    // Strobes in {r3_w1, r2_w0, r1_w3, r0_w2} order; each fires only on the last step of its phase.
    assign w_strb     = {r3_w1_en, r2_w0_en, r1_w3_en, r0_w2_en};
    assign w_last     = (w_step == LAST_STEP);
    assign w_exp_strb = {w_last && (w_phase == PHASE_W'(0)),
                         w_last && (w_phase == PHASE_W'(3)),
                         w_last && (w_phase == PHASE_W'(2)),
                         w_last && (w_phase == PHASE_W'(1))};
    assign w_in_seq   = w_legal && (w_phase == r_exp_phase) && (w_step == r_exp_step);

    // Expected state only ever advances to the successor of the decoded word.
    assign w_succ_phase = w_last ? (w_phase + PHASE_W'(1)) : w_phase;
    assign w_succ_step  = w_last ? '0 : (w_step + SW'(1));

    // Error classification with illegal > sequence > strobe priority.
    always_comb begin
        w_class = ERR_NONE;
        if (!w_legal) begin
            w_class = ERR_ILLEGAL;
        end else if (!w_in_seq) begin
            w_class = ERR_SEQ;
        end else if (w_strb != w_exp_strb) begin
            w_class = ERR_STRB;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control decisions.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_match_cnt;
        w_load_exp   = 1'b0;
        w_err_fire   = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_legal) begin
                    w_load_exp = 1'b1;
                    w_cnt_next = 8'd1;
                    if (lock_cycles == 1) begin
                        w_state_next = LOCKED;
                    end else begin
                        w_state_next = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (w_class == ERR_NONE) begin
                    w_load_exp = 1'b1;
                    w_cnt_next = r_match_cnt + 8'd1;
                    if ((r_match_cnt + 8'd1) == LOCK_N) begin
                        w_state_next = LOCKED;
                    end
                end else begin
                    w_cnt_next   = 8'd0;
                    w_state_next = SEARCH;
                end
            end
            LOCKED: begin
                if (w_class == ERR_NONE) begin
                    w_load_exp = 1'b1;
                end else begin
                    w_err_fire   = 1'b1;
                    w_cnt_next   = 8'd0;
                    w_state_next = SEARCH;
                end
            end
            default: begin
                w_cnt_next   = 8'd0;
                w_state_next = SEARCH;
            end
        endcase
    end

    // Datapath registers: expectation, decoded outputs and error reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_cnt <= 8'd0;
            r_exp_phase <= '0;
            r_exp_step  <= '0;
            r_phase     <= '0;
            r_step      <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= '0;
        end else begin
            r_match_cnt <= w_cnt_next;
            r_err       <= w_err_fire;
            if (w_load_exp) begin
                r_exp_phase <= w_succ_phase;
                r_exp_step  <= w_succ_step;
            end
            if (w_legal) begin
                r_phase <= w_phase;
                r_step  <= w_step;
            end
            if (w_err_fire) begin
                r_err_code <= w_class;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + cnt_w'(1);
                end
            end
        end
    end

`ifdef PSU_MON_ERR_CAPTURE_EN
    logic [steps:0] r_cap_ctl0;
    logic [steps:0] r_cap_ctl1;
    logic [3:0]     r_cap_strb;
    logic           r_cap_valid;

    // Latch the first locked-state error sample; sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_ctl0  <= '0;
            r_cap_ctl1  <= '0;
            r_cap_strb  <= '0;
            r_cap_valid <= 1'b0;
        end else if (w_err_fire && !r_cap_valid) begin
            r_cap_ctl0  <= ctl0;
            r_cap_ctl1  <= ctl1;
            r_cap_strb  <= w_strb;
            r_cap_valid <= 1'b1;
        end
    end

    assign cap_ctl0  = r_cap_ctl0;
    assign cap_ctl1  = r_cap_ctl1;
    assign cap_strb  = r_cap_strb;
    assign cap_valid = r_cap_valid;
`endif

    assign locked    = (r_state == LOCKED);
    assign phase_o   = r_phase;
    assign step_o    = r_step;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign err_count = r_err_count;

endmodule
